// File: rtl/mac4_accum_collector_if.sv
// mac4_accum_collector_if
//   Stream bundle for mac4_accum_collector.
//   Upstream side : in_valid, in_data (signed partial sum), stall (upstream ce = ~stall)
//   Downstream side: out_valid, out_data (signed result), out_ready
//   Status        : fifo_count (occupied result entries), sat_flag (sticky clamp flag)
//   Modports: master = driver/consumer environment, slave = the collector.
interface mac4_accum_collector_if #(
  parameter int SUM_W      = 18,
  parameter int OUT_W      = 16,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                    in_valid;
  logic signed [SUM_W-1:0] in_data;
  logic                    stall;
  logic                    out_valid;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_ready;
  logic [CW-1:0]           fifo_count;
  logic                    sat_flag;

  modport master (
    output in_valid, in_data, out_ready,
    input  stall, out_valid, out_data, fifo_count, sat_flag
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output stall, out_valid, out_data, fifo_count, sat_flag
  );
endinterface

// File: rtl/mac4_accum_collector.sv
// mac4_accum_collector
//   Accumulates NBEATS signed partial sums from a 4-term MAC stage into one
//   dot-product result, converts it to OUT_W bits and queues it in a small
//   result FIFO. stall is asserted while the FIFO is full so upstream freezes.
//
//   Ports:
//     clk   - single clock, rising edge
//     rst   - asynchronous active-high reset (clears everything incl. sat_flag)
//     flush - synchronous discard of the partial sum and the FIFO contents
//     bus   - mac4_accum_collector_if.slave: in_valid/in_data/stall,
//             out_valid/out_data/out_ready, fifo_count, sat_flag
//
//   Optional feature macro: MAC4_ACCUM_SATURATE_EN
//     defined   -> results clamp to the OUT_W signed range, sat_flag is sticky
//     undefined -> results truncate to the low OUT_W bits, sat_flag is 0
module mac4_accum_collector #(
  parameter int SUM_W      = 18,
  parameter int NBEATS     = 4,
  parameter int ACC_W      = SUM_W + 8,
  parameter int OUT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input logic                   clk,
  input logic                   rst,
  input logic                   flush,
  mac4_accum_collector_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  logic [BW-1:0]           beat_q, beat_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [AW-1:0]           wr_q, wr_d;
  logic [AW-1:0]           rd_q, rd_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic signed [OUT_W-1:0] mem [FIFO_DEPTH];

  logic                    stall_w;
  logic                    accept;
  logic                    last;
  logic                    push;
  logic                    pop;
  logic signed [ACC_W-1:0] in_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [OUT_W-1:0] res;

`ifdef MAC4_ACCUM_SATURATE_EN
  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  logic sat_q, sat_d;
  logic clamp;
`endif

  // stall depends only on the registered count, so out_ready never reaches it
  // combinationally; a pop from full therefore frees the slot one cycle later.
  assign stall_w = (cnt_q == FULL_CNT);

  always_comb begin
    accept = bus.in_valid & ~stall_w;
    last   = (beat_q == LAST_BEAT);
    push   = accept & last;
    pop    = (cnt_q != '0) & bus.out_ready;
    in_ext = ACC_W'(bus.in_data);
    // Beat 0 starts a fresh sum, so a stale acc never needs clearing.
    sum    = (beat_q == '0) ? in_ext : acc_q + in_ext;

`ifdef MAC4_ACCUM_SATURATE_EN
    clamp = 1'b0;
    if (sum > MAXV) begin
      res   = MAXV[OUT_W-1:0];
      clamp = 1'b1;
    end else if (sum < MINV) begin
      res   = MINV[OUT_W-1:0];
      clamp = 1'b1;
    end else begin
      res   = sum[OUT_W-1:0];
    end
`else
    res = sum[OUT_W-1:0];
`endif

    beat_d = beat_q;
    acc_d  = acc_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
`ifdef MAC4_ACCUM_SATURATE_EN
    sat_d  = sat_q;
`endif

    if (accept) begin
      acc_d  = sum;
      beat_d = last ? '0 : beat_q + BW'(1);
    end
    if (push) wr_d = wr_q + AW'(1);
    if (pop)  rd_d = rd_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    // flush wins over push/pop; sat_flag is deliberately untouched by it.
    if (flush) begin
      beat_d = '0;
      acc_d  = '0;
      wr_d   = '0;
      rd_d   = '0;
      cnt_d  = '0;
    end
`ifdef MAC4_ACCUM_SATURATE_EN
    else if (push && clamp) begin
      sat_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q <= '0;
      acc_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
`ifdef MAC4_ACCUM_SATURATE_EN
      sat_q  <= 1'b0;
`endif
    end else begin
      beat_q <= beat_d;
      acc_q  <= acc_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
`ifdef MAC4_ACCUM_SATURATE_EN
      sat_q  <= sat_d;
`endif
    end
  end

  // Storage needs no reset: entries are only visible while cnt_q says so.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_q] <= res;
  end

  assign bus.stall      = stall_w;
  assign bus.out_valid  = (cnt_q != '0);
  assign bus.out_data   = mem[rd_q];
  assign bus.fifo_count = cnt_q;
`ifdef MAC4_ACCUM_SATURATE_EN
  assign bus.sat_flag   = sat_q;
`else
  assign bus.sat_flag   = 1'b0;
`endif

endmodule

// File: tb/tb_mac4_accum_collector.sv
module tb_mac4_accum_collector;

  logic clk;
  logic rst;
  logic flush;
  int   checks;
  int   errors;

  mac4_accum_collector_if #(.SUM_W(18), .OUT_W(16), .FIFO_DEPTH(4)) bus ();

  mac4_accum_collector #(
    .SUM_W(18),
    .NBEATS(4),
    .ACC_W(26),
    .OUT_W(16),
    .FIFO_DEPTH(4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MAC4_ACCUM_SATURATE_EN
  localparam int SAT_RES  = 32767;
  localparam int SAT_FLAG = 1;
`else
  localparam int SAT_RES  = 14464;
  localparam int SAT_FLAG = 0;
`endif

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int v);
    bus.in_valid = 1'b1;
    bus.in_data  = 18'(v);
    tick();
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_stall", 32'(bus.stall), 0);
    chk("rst_count", 32'(bus.fifo_count), 0);
    chk("rst_sat", 32'(bus.sat_flag), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("post_rst_out_valid", 32'(bus.out_valid), 0);

    // accumulation: 10 - 3 + 7 + 100 = 114, visible one cycle after beat 4
    bus.out_ready = 1'b1;
    beat(10);
    beat(-3);
    beat(7);
    chk("acc_no_early_valid", 32'(bus.out_valid), 0);
    beat(100);
    chk("acc_valid", 32'(bus.out_valid), 1);
    chk("acc_data", 32'(bus.out_data), 114);
    bus.in_valid = 1'b0;
    tick();
    chk("acc_valid_one_cycle", 32'(bus.out_valid), 0);

    // backpressure: 16 beats of 1 fill the FIFO with four 4s
    bus.out_ready = 1'b0;
    repeat (16) beat(1);
    chk("bp_count_full", 32'(bus.fifo_count), 4);
    chk("bp_stall", 32'(bus.stall), 1);
    chk("bp_head", 32'(bus.out_data), 4);
    repeat (4) beat(1);
    chk("bp_ignored_count", 32'(bus.fifo_count), 4);
    bus.in_valid = 1'b0;

    // pop from full: stall holds through the pop cycle, drops after
    bus.out_ready = 1'b1;
    chk("fullpop_stall_same", 32'(bus.stall), 1);
    tick();
    chk("fullpop_stall_next", 32'(bus.stall), 0);
    chk("fullpop_count", 32'(bus.fifo_count), 3);
    for (int i = 0; i < 3; i++) begin
      chk("drain_data", 32'(bus.out_data), 4);
      tick();
    end
    chk("drain_empty", 32'(bus.out_valid), 0);
    bus.out_ready = 1'b0;

    // beats offered while stalled must not have advanced the beat counter
    repeat (4) beat(2);
    chk("align_count", 32'(bus.fifo_count), 1);
    chk("align_data", 32'(bus.out_data), 8);

    // simultaneous push and pop: 8 leaves, 12 arrives, count stays 1
    repeat (3) beat(3);
    bus.out_ready = 1'b1;
    beat(3);
    chk("pushpop_count", 32'(bus.fifo_count), 1);
    chk("pushpop_data", 32'(bus.out_data), 12);
    bus.in_valid = 1'b0;
    tick();
    chk("pushpop_drained", 32'(bus.fifo_count), 0);
    bus.out_ready = 1'b0;

    // saturation / truncation: 4 x 20000 = 80000
    repeat (4) beat(20000);
    chk("sat_data", 32'(bus.out_data), SAT_RES);
    chk("sat_flag", 32'(bus.sat_flag), SAT_FLAG);

    // flush with 2 entries queued and 3 beats in flight plus one same-cycle beat
    repeat (4) beat(1);
    chk("pre_flush_count", 32'(bus.fifo_count), 2);
    repeat (3) beat(7);
    flush = 1'b1;
    beat(7);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_count", 32'(bus.fifo_count), 0);
    chk("flush_out_valid", 32'(bus.out_valid), 0);
    chk("flush_stall", 32'(bus.stall), 0);
    chk("flush_keeps_sat", 32'(bus.sat_flag), SAT_FLAG);
    repeat (4) beat(5);
    chk("post_flush_data", 32'(bus.out_data), 20);

    // async reset mid-accumulation with one result still queued
    repeat (2) beat(9);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(bus.out_valid), 0);
    chk("async_rst_count", 32'(bus.fifo_count), 0);
    chk("async_rst_sat", 32'(bus.sat_flag), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) beat(5);
    bus.in_valid = 1'b0;
    chk("post_rst_count", 32'(bus.fifo_count), 1);
    chk("post_rst_data", 32'(bus.out_data), 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac4_accum_collector.md
MAC4_ACCUM_COLLECTOR -- requirements
Module: mac4_accum_collector

Interface
REQ-001 SHALL have parameter SUM_W, default 18: width of incoming 4-term partial sum.
REQ-002 SHALL have parameter NBEATS, default 4: partial sums per dot product (K = 4*NBEATS); legal range 1 to 256.
REQ-003 SHALL have parameter ACC_W, default SUM_W+8: internal accumulator width.
REQ-004 SHALL have parameter OUT_W, default 16: result width.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4: result FIFO entries; must be a power of 2, at least 2.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset; asynchronous and active-high.
REQ-008 SHALL have port flush, input, 1 bit: synchronous discard of partial sum and FIFO contents.
REQ-009 SHALL have port in_valid, input, 1 bit: in_data holds a partial sum.
REQ-010 SHALL have port in_data, input, SUM_W bits, signed: partial sum from the upstream MAC stage.
REQ-011 SHALL have port stall, output, 1 bit: upstream ce = ~stall.
REQ-012 SHALL have port out_valid, output, 1 bit: FIFO head is valid.
REQ-013 SHALL have port out_data, output, OUT_W bits, signed: FIFO head result.
REQ-014 SHALL have port out_ready, input, 1 bit: consumer accepts the head.
REQ-015 SHALL have port fifo_count, output, clog2(FIFO_DEPTH)+1 bits: occupied entries.
REQ-016 SHALL have port sat_flag, output, 1 bit: sticky saturation indicator.

Function
REQ-017 SHALL accept a beat only in a cycle where in_valid=1 and stall=0; in_valid while stall=1 is ignored, because upstream holds its output frozen.
REQ-018 SHALL drive stall = (fifo_count == FIFO_DEPTH) from registered state only, with no combinational path from out_ready.
REQ-019 SHALL keep beat counter beat_cnt in the range 0 to NBEATS-1.
REQ-020 SHALL, on an accepted beat with beat_cnt=0, load acc with sign-extended in_data; otherwise acc SHALL become acc plus sign-extended in_data.
REQ-021 SHALL, on the accepted beat with beat_cnt=NBEATS-1, write the full sum (acc plus in_data) to the FIFO after OUT_W conversion and wrap beat_cnt to 0.
REQ-022 SHALL treat NBEATS=1 so that every accepted beat is also a final beat.
REQ-023 SHALL, when SATURATE_EN is absent, perform OUT_W conversion as two's-complement truncation to the low OUT_W bits.
REQ-024 SHALL present a result on out_valid/out_data in the cycle after its final beat is accepted (latency 1 clock).
REQ-025 SHALL pop the FIFO head on out_valid=1 and out_ready=1, in order.
REQ-026 SHALL take out_data directly from FIFO storage and keep it stable while out_valid=1 and out_ready=0.
REQ-027 SHALL, on a simultaneous push and pop, leave fifo_count unchanged and keep the data correct.
REQ-028 SHALL, when the FIFO is full and a pop occurs, keep stall high for that cycle and deassert it the following cycle.
REQ-029 SHALL, on flush=1, clear beat_cnt, acc, the FIFO pointers and fifo_count on the next edge, discarding a beat accepted in the same cycle.
REQ-030 SHALL NOT let flush clear sat_flag.
REQ-031 SHALL make flush take priority over push and pop.

Reset
REQ-032 SHALL, on rst=1 and asynchronously, clear beat_cnt, acc, the FIFO pointers, fifo_count and sat_flag.
REQ-033 SHALL hold out_valid=0 and stall=0 during and after reset; out_data is don't-care while out_valid=0.
REQ-034 SHALL discard a partial accumulation in progress when rst is asserted mid-accumulation; the next accepted beat after release is treated as beat 0.

Configuration
REQ-035 SHALL, when macro MAC4_ACCUM_SATURATE_EN is defined, clamp the result to the range -2^(OUT_W-1) to 2^(OUT_W-1)-1 on FIFO write.
REQ-036 SHALL, when MAC4_ACCUM_SATURATE_EN is defined, set sat_flag on any write that clamps; sat_flag stays set until rst.
REQ-037 SHALL, without MAC4_ACCUM_SATURATE_EN, use truncation per REQ-023 and tie sat_flag to 0; the port list is identical in both builds.

Verification
REQ-038 SHALL cover accumulation: NBEATS=4, beats 10,-3,7,100 on consecutive cycles, out_ready=1 -> out_data=114 one cycle after beat 4, out_valid high for 1 cycle.
REQ-039 SHALL cover backpressure: out_ready=0, continuous beats of 1 -> after 4 results fifo_count=4 and stall=1; beats ignored while stalled; popping 4 results yields 4,4,4,4.
REQ-040 SHALL cover full-FIFO pop: FIFO full, pop 1 -> stall stays 1 that cycle, is 0 next cycle, and fifo_count reads 3.
REQ-041 SHALL cover saturation: OUT_W=16, beats 20000 x4 -> 32767 with sat_flag=1 when MAC4_ACCUM_SATURATE_EN is defined, and 80000 mod 2^16 = 14464 with sat_flag=0 without it.
REQ-042 SHALL cover reset and flush: rst after 2 beats, then beats 5,5,5,5 -> result 20; flush after 3 beats with a 2-entry FIFO -> fifo_count=0 and out_valid=0 next cycle.
